// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller that drives memory6x8 as a synchronous FIFO.
// Optional sticky overflow/underflow error flags are built only when FIFO_CTRL_ERR_EN is defined.
module fifo_ctrl #(
    parameter int MAIN_SIZE = 6,
    parameter int AF_LEVEL  = 60,
    parameter int AE_LEVEL  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    output logic                 write,
    output logic                 read,
    output logic [MAIN_SIZE-1:0] wr_ptr,
    output logic [MAIN_SIZE-1:0] rd_ptr,
    output logic [MAIN_SIZE:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 valid_out,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [MAIN_SIZE:0] DEPTH_C = {1'b1, {MAIN_SIZE{1'b0}}};
    localparam logic [MAIN_SIZE:0] AF_C    = AF_LEVEL[MAIN_SIZE:0];
    localparam logic [MAIN_SIZE:0] AE_C    = AE_LEVEL[MAIN_SIZE:0];

    // Strobes are gated by reset so the memory sees no access while the controller is held.
    // A push while full or a pop while empty is simply rejected, which also resolves
    // the simultaneous push/pop corner cases without extra logic.
    assign write = reset & push & ~full;
    assign read  = reset & pop & ~empty;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            valid_out <= 1'b0;
        end else begin
            if (write) wr_ptr <= wr_ptr + 1'b1;
            if (read)  rd_ptr <= rd_ptr + 1'b1;
            case ({write, read})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            valid_out <= read;
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full)  overflow  <= 1'b1;
            if (pop  && empty) underflow <= 1'b1;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule
